mult_seq_ctrl: RTL and testbench

- Moore FSM sequencer for the shift-add micro-multiplier datapath.
- Accepts a start request, loads operands, and iterates WIDTH test/add/shift steps using the datapath's multiplier-LSB flag.
- Drives the datapath's 13-bit control word, then latches the product into the output register and reports done.
- Sits between the top-level pin wrapper and the datapath; the only block that drives datapath enables.

---
 rtl/mult_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_mult_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Moore sequencer for the shift-add multiplier datapath: LOAD, then WIDTH x (TEST [ADD] SHIFT), then DONE.
// Optional START_ERR_EN adds a sticky err output flagging start requests made while busy.
module mult_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       flag,
  output logic       busy,
  output logic       done,
  output logic       enA,
  output logic       enB,
  output logic       enDPO,
  output logic       ABsel,
  output logic       sr_c1,
  output logic       sr_c0,
  output logic       enSR,
  output logic       SRsel,
  output logic       alu_c2,
  output logic       alu_c1,
  output logic       alu_c0,
  output logic       enACC,
  output logic       clrACC,
`ifdef START_ERR_EN
  output logic       err,
`endif
  output logic [2:0] state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Handshake: start is a request that is accepted only when busy=0 (IDLE);
  // there is no ready, a start seen while busy=1 is dropped, and done pulses once per accepted start.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    cnt_d   = cnt_q;
    busy    = 1'b1;
    done    = 1'b0;
    enA     = 1'b0;
    enB     = 1'b0;
    enDPO   = 1'b0;
    ABsel   = 1'b0;
    sr_c1   = 1'b0;
    sr_c0   = 1'b0;
    enSR    = 1'b0;
    SRsel   = 1'b0;
    alu_c2  = 1'b0;
    alu_c1  = 1'b0;
    alu_c0  = 1'b0;
    enACC   = 1'b0;
    clrACC  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy    = 1'b0;
        state_d = start ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        enA     = 1'b1;
        enB     = 1'b1;
        clrACC  = 1'b1;
        enSR    = 1'b1;
        sr_c1   = 1'b1;
        sr_c0   = 1'b1;
        cnt_d   = CNT_INIT;
        state_d = S_TEST;
      end
      S_TEST: begin
        state_d = flag ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        alu_c0  = 1'b1;
        enACC   = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        enSR    = 1'b1;
        sr_c0   = 1'b1;
        SRsel   = 1'b1;
        alu_c1  = 1'b1;
        enACC   = 1'b1;
        // Saturate at zero so a corrupted count still terminates the sequence.
        cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
        state_d = (cnt_q <= CW'(1)) ? S_DONE : S_TEST;
      end
      S_DONE: begin
        enDPO   = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef START_ERR_EN
  // Sticky until the next accepted start; an unused encoding counts as busy.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      err <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (start) err <= 1'b0;
    end else if (start) begin
      err <= 1'b1;
    end
  end
`endif

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: a datapath model reacts to the control word, expected state order and
// product come from the multiplier bits and plain arithmetic. Build with START_ERR_EN to check err.
module tb_mult_seq_ctrl;
  localparam int W = 4;

  localparam int B_BUSY = 14, B_DONE = 13, B_ENA = 12, B_ENB = 11, B_DPO = 10, B_ABSEL = 9;
  localparam int B_SRC1 = 8, B_SRC0 = 7, B_ENSR = 6, B_SRSEL = 5;
  localparam int B_ALU2 = 4, B_ALU1 = 3, B_ALU0 = 2, B_ENACC = 1, B_CLR = 0;

  logic sys_clk = 1'b0;
  logic sys_rst, start, flag;
  logic busy, done, enA, enB, enDPO, ABsel, sr_c1, sr_c0, enSR, SRsel;
  logic alu_c2, alu_c1, alu_c0, enACC, clrACC;
  logic [2:0] state_dbg;
`ifdef START_ERR_EN
  logic err;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef enum {L_IDLE, L_LOAD, L_TEST, L_ADD, L_SHIFT, L_DONE} label_t;

  logic [14:0] obs;
  assign obs = {busy, done, enA, enB, enDPO, ABsel, sr_c1, sr_c0, enSR, SRsel,
                alu_c2, alu_c1, alu_c0, enACC, clrACC};

  // datapath model and operand inputs
  logic [W-1:0]   a_in, b_in, a_m, b_m, sr_m;
  logic [W:0]     acc_m;
  logic [2*W-1:0] dpo_m;
  bit             err_exp;
  logic [2:0]     idle_dbg;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .flag(flag),
    .busy(busy), .done(done), .enA(enA), .enB(enB), .enDPO(enDPO), .ABsel(ABsel),
    .sr_c1(sr_c1), .sr_c0(sr_c0), .enSR(enSR), .SRsel(SRsel),
    .alu_c2(alu_c2), .alu_c1(alu_c1), .alu_c0(alu_c0), .enACC(enACC), .clrACC(clrACC),
`ifdef START_ERR_EN
    .err(err),
`endif
    .state_dbg(state_dbg)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [14:0] word_of(label_t l);
    logic [14:0] w;
    w = '0;
    case (l)
      L_LOAD:  begin w[B_BUSY] = 1; w[B_ENA] = 1; w[B_ENB] = 1; w[B_CLR] = 1;
                     w[B_ENSR] = 1; w[B_SRC1] = 1; w[B_SRC0] = 1; end
      L_TEST:  w[B_BUSY] = 1;
      L_ADD:   begin w[B_BUSY] = 1; w[B_ALU0] = 1; w[B_ENACC] = 1; end
      L_SHIFT: begin w[B_BUSY] = 1; w[B_ENSR] = 1; w[B_SRC0] = 1; w[B_SRSEL] = 1;
                     w[B_ALU1] = 1; w[B_ENACC] = 1; end
      L_DONE:  begin w[B_BUSY] = 1; w[B_DONE] = 1; w[B_DPO] = 1; end
      default: w = '0;
    endcase
    return w;
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Datapath reaction to the word currently driven; all updates use pre-edge values.
  task automatic model_step();
    logic [W:0]   acc_o;
    logic [W-1:0] sr_o;
    acc_o = acc_m;
    sr_o  = sr_m;
    if (obs[B_ENA]) a_m = a_in;
    if (obs[B_ENB]) b_m = b_in;
    if (obs[B_ENSR]) begin
      if (obs[B_SRC1] && obs[B_SRC0]) sr_m = b_in;
      else if (!obs[B_SRC1] && obs[B_SRC0]) sr_m = {obs[B_SRSEL] ? acc_o[0] : 1'b0, sr_o[W-1:1]};
    end
    if (obs[B_CLR]) acc_m = '0;
    else if (obs[B_ENACC]) begin
      if (obs[B_ALU2:B_ALU0] == 3'b001)
        acc_m = {1'b0, acc_o[W-1:0]} + {1'b0, (obs[B_ABSEL] ? b_m : a_m)};
      else if (obs[B_ALU2:B_ALU0] == 3'b010)
        acc_m = {1'b0, acc_o[W:1]};
    end
    if (obs[B_DPO]) dpo_m = {acc_m[W-1:0], sr_m};
  endtask

  task automatic err_update(bit is_idle);
    if (is_idle && start) err_exp = 1'b0;
    else if (!is_idle && start) err_exp = 1'b1;
  endtask

  task automatic check_err(string name, int cyc);
`ifdef START_ERR_EN
    tests_run++;
    if (err !== err_exp) begin
      tests_failed++;
      $display("FAIL %s err cyc%0d got %b exp %b", name, cyc, err, err_exp);
    end
`endif
  endtask

  // Runs one multiply from IDLE. Ends in the IDLE cycle after DONE (or after a reset abort).
  task automatic run_seq(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold_start,
                         input bit pulse_mid, input bit abort_add2, input string name);
    label_t exp_q[$];
    label_t lab;
    int cyc, done_cyc, adds, k;
    exp_q = {};
    exp_q.push_back(L_LOAD);
    for (int i = 0; i < W; i++) begin
      exp_q.push_back(L_TEST);
      if (b[i]) exp_q.push_back(L_ADD);
      exp_q.push_back(L_SHIFT);
    end
    exp_q.push_back(L_DONE);
    exp_q.push_back(L_IDLE);
    k = $countones(b);
    a_in = a;
    b_in = b;
    dpo_m = 'x;
    start = 1'b1;
    err_update(1'b1);
    model_step();
    step();
    cyc = 1;
    done_cyc = -1;
    adds = 0;
    while (exp_q.size() > 0) begin
      lab = exp_q.pop_front();
      flag = (lab == L_TEST) ? sr_m[0] : 1'($urandom_range(0, 1));
      start = hold_start || (pulse_mid && (cyc == 3 || cyc == 11));
      tests_run++;
      if (obs !== word_of(lab)) begin
        tests_failed++;
        $display("FAIL %s word cyc%0d got %b exp %b", name, cyc, obs, word_of(lab));
      end
      check_err(name, cyc);
      if (lab == L_LOAD && name == "3x5") begin
        tests_run++;
        if (state_dbg === idle_dbg) begin
          tests_failed++;
          $display("FAIL %s state_dbg in LOAD got %0d exp not %0d", name, state_dbg, idle_dbg);
        end
      end
      if (obs[B_DONE] && done_cyc < 0) done_cyc = cyc;
      err_update(lab == L_IDLE);
      model_step();
      if (abort_add2 && lab == L_ADD) begin
        adds++;
        if (adds == 2) begin
          start = 1'b0;
          #2 sys_rst = 1'b1;
          #1;
          err_exp = 1'b0;
          tests_run++;
          if (obs !== '0) begin
            tests_failed++;
            $display("FAIL %s async reset outputs got %b exp 0", name, obs);
          end
          check_err(name, cyc);
          for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (obs !== '0) begin
              tests_failed++;
              $display("FAIL %s held reset outputs got %b exp 0", name, obs);
            end
          end
          sys_rst = 1'b0;
          for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if (obs !== '0) begin
              tests_failed++;
              $display("FAIL %s idle after reset got %b exp 0", name, obs);
            end
          end
          return;
        end
      end
      if (exp_q.size() > 0) begin
        step();
        cyc++;
      end
    end
    tests_run++;
    if (done_cyc != 2 + 2 * W + k) begin
      tests_failed++;
      $display("FAIL %s done cycle got %0d exp %0d", name, done_cyc, 2 + 2 * W + k);
    end
    tests_run++;
    if (dpo_m !== 2 * W'(a) * 0 + a * b) begin
      tests_failed++;
      $display("FAIL %s product got %0d exp %0d", name, dpo_m, a * b);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    start = 1'b0;
    flag = 1'b0;
    a_in = '0;
    b_in = '0;
    a_m = '0;
    b_m = '0;
    sr_m = '0;
    acc_m = '0;
    err_exp = 1'b0;
    repeat (3) step();
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("FAIL reset outputs got %b exp 0", obs);
    end
    check_err("reset", 0);
    sys_rst = 1'b0;
    step();
    idle_dbg = state_dbg;
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("FAIL reset release idle got %b exp 0", obs);
    end
    // begin a sequence, then reset mid-cycle
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset pre-abort busy got %b exp 1", busy);
    end
    #3 sys_rst = 1'b1;
    #1;
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("FAIL reset mid-cycle outputs got %b exp 0", obs);
    end
    step();
    #2 sys_rst = 1'b0;
    err_exp = 1'b0;
    repeat (2) step();
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("FAIL reset stay idle got %b exp 0", obs);
    end
    check_err("reset", 0);
  endtask

  task automatic test_3x5();
    run_seq(4'd3, 4'd5, 1'b0, 1'b0, 1'b0, "3x5");
  endtask

  task automatic test_0x0();
    run_seq(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "0x0");
  endtask

  task automatic test_15x15();
    run_seq(4'd15, 4'd15, 1'b0, 1'b0, 1'b0, "15x15");
  endtask

  task automatic test_start_while_busy();
    run_seq(4'd3, 4'd5, 1'b0, 1'b1, 1'b0, "start_busy");
    run_seq(4'd6, 4'd9, 1'b0, 1'b0, 1'b0, "after_busy");
  endtask

  task automatic test_reset_mid_op();
    run_seq(4'd15, 4'd15, 1'b0, 1'b0, 1'b1, "abort_15x15");
    run_seq(4'd15, 4'd15, 1'b0, 1'b0, 1'b0, "rerun_15x15");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_seq(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0, "random");
  endtask

  task automatic test_back_to_back();
    run_seq(4'd7, 4'd11, 1'b1, 1'b0, 1'b0, "b2b_0");
    run_seq(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0, "b2b_1");
    run_seq(4'd9, 4'd1, 1'b0, 1'b0, 1'b0, "b2b_2");
  endtask

  initial begin
    test_reset();
    test_3x5();
    test_0x0();
    test_15x15();
    test_start_while_busy();
    test_reset_mid_op();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
